// File: rtl/uart_tx_if.sv
// Handshake and line signals between a UART transmitter and its byte source.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_start;
  logic                  tx_ready;
  logic                  tx;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_data, tx_start,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, STOP_BITS stop bits. Bit timing from an internal bit-period counter.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, ready to accept a request
// S_START  | driving the start bit (0)
// S_DATA   | driving shreg[0], shifting right at each bit end
// S_PARITY | driving the latched parity bit
// S_STOP   | driving stop bit(s) (1), tx_done on the final bit end
module uart_tx #(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_WIDTH    = 8,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int BIT_CNT = CLK_FREQUENCE / BAUD_RATE - 1;
  localparam int CNT_W   = (BIT_CNT > 0) ? $clog2(BIT_CNT + 1) : 1;
  localparam int IDX_W   = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  tx_q, tx_n;
  logic                  bit_end;
  logic                  accept;

  assign bit_end = (bit_cnt == CNT_LAST);
  assign accept  = (state == S_IDLE) && bus.tx_start;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and the line level for the next cycle; tx is registered so the
  // line only ever changes at a bit boundary.
  always_comb begin
    state_n = state;
    tx_n    = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = shreg[0];
        end
      end
      S_DATA: begin
        tx_n = shreg[0];
        if (bit_end) begin
          if (bit_idx == DATA_LAST) begin
            if (PARITY_EN != 0) begin
              state_n = S_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            // shreg shifts at this edge, so the next bit is shreg[1] now
            tx_n = shreg[1];
          end
        end
      end
      S_PARITY: begin
        tx_n = par_bit;
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end && (bit_idx == STOP_LAST)) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Registered line driver, idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= 1'b1;
    else        tx_q <= tx_n;
  end

  // Bit-period counter, bit index, shift register and parity latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if ((state == S_IDLE) || bit_end) bit_cnt <= '0;
      else                              bit_cnt <= bit_cnt + CNT_W'(1);

      if (accept) begin
        shreg   <= bus.tx_data;
        par_bit <= (PARITY_ODD != 0) ? ~^bus.tx_data : ^bus.tx_data;
        bit_idx <= '0;
      end else if (bit_end) begin
        if (state == S_DATA) begin
          shreg   <= shreg >> 1;
          // bit_idx is reused to count stop bits, so wrap it leaving DATA
          bit_idx <= (bit_idx == DATA_LAST) ? '0 : bit_idx + IDX_W'(1);
        end else if (state == S_STOP) begin
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (state == S_IDLE);
  assign bus.tx_busy  = (state != S_IDLE);
  assign bus.tx_done  = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven by the same request stream,
// every cycle compared against a frame-level reference model.
module tb_uart_tx;

  localparam int P = 10;

  localparam int PEN  [4] = '{0, 1, 1, 0};
  localparam int PODD [4] = '{0, 0, 1, 0};
  localparam int STP  [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s = 1'b0;
  logic [7:0] data_s = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(8)) if0 ();
  uart_tx_if #(.DATA_WIDTH(8)) if1 ();
  uart_tx_if #(.DATA_WIDTH(8)) if2 ();
  uart_tx_if #(.DATA_WIDTH(8)) if3 ();

  assign if0.tx_start = start_s;
  assign if1.tx_start = start_s;
  assign if2.tx_start = start_s;
  assign if3.tx_start = start_s;
  assign if0.tx_data  = data_s;
  assign if1.tx_data  = data_s;
  assign if2.tx_data  = data_s;
  assign if3.tx_data  = data_s;

  uart_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  uart_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  uart_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  uart_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
            .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // {tx, tx_ready, tx_busy, tx_done}
  logic [3:0] obs [4];
  assign obs[0] = {if0.tx, if0.tx_ready, if0.tx_busy, if0.tx_done};
  assign obs[1] = {if1.tx, if1.tx_ready, if1.tx_busy, if1.tx_done};
  assign obs[2] = {if2.tx, if2.tx_ready, if2.tx_busy, if2.tx_done};
  assign obs[3] = {if3.tx, if3.tx_ready, if3.tx_busy, if3.tx_done};

  // Reference model: a frame is a list of line bits, each held P cycles.
  function automatic logic frame_bit(input int i, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if ((b == 9) && (PEN[i] != 0))
      return logic'(($countones(d) % 2) == 1) ^ logic'(PODD[i] != 0);
    return 1'b1;
  endfunction

  function automatic int flen(input int i);
    return (1 + 8 + PEN[i] + STP[i]) * P;
  endfunction

  int   rem [4];
  int   pos [4];
  logic fb  [4][13];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rem[i] <= 0;
        pos[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          if (start_s) begin
            rem[i] <= flen(i);
            pos[i] <= 0;
            for (int b = 0; b < 13; b++) fb[i][b] <= frame_bit(i, data_s, b);
          end
        end else begin
          rem[i] <= rem[i] - 1;
          pos[i] <= pos[i] + 1;
        end
      end
    end
  end

  function automatic logic [3:0] model_out(input int i);
    if (rem[i] > 0) return {fb[i][pos[i] / P], 1'b0, 1'b1, logic'(rem[i] == 1)};
    return 4'b1100;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: land on the falling edge and compare every instance to the model.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("line_inst%0d", i), 32'(obs[i]), 32'(model_out(i)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(obs[0][2] && obs[1][2] && obs[2][2] && obs[3][2]) && (n < 500)) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 500), 32'd1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] fr;   // inst0 line bits, fr[0] sent first
    logic       pe;   // even parity bit
    logic       po;   // odd parity bit
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v);
    wait_idle();
    data_s  = v.d;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 1; c <= 101; c++) begin
      if ((c <= 100) && (((c - 1) % P) == 4))
        chk($sformatf("bit%0d_%h", (c - 1) / P, v.d), 32'(obs[0][3]), 32'(v.fr[(c - 1) / P]));
      if (c == 95) begin
        chk($sformatf("par_even_%h", v.d), 32'(obs[1][3]), 32'(v.pe));
        chk($sformatf("par_odd_%h", v.d), 32'(obs[2][3]), 32'(v.po));
      end
      if (c == 100) chk($sformatf("done_%h", v.d), 32'(obs[0][0]), 32'd1);
      if (c == 101) chk($sformatf("ready_%h", v.d), 32'(obs[0][2]), 32'd1);
      if (c < 101) tick();
    end
  endtask

  initial begin
    int n;
    int m;

    vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0, 1'b1};
    vecs[1] = '{8'h07, 10'b1_0000_0111_0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 10'b1_0000_0000_0, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 10'b1_1111_1111_0, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 10'b1_0011_1100_0, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 10'b1_0000_0001_0, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 10'b1_0111_1111_0, 1'b1, 1'b0};
    vecs[7] = '{8'h81, 10'b1_1000_0001_0, 1'b0, 1'b1};

    // Reset and quiet line
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) tick();
    chk("reset_state", 32'(obs[0]), 32'b1100);

    // Single frames, all configurations
    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    // Held request, two stop bits: 00 then FF, exactly one idle cycle between
    wait_idle();
    data_s  = 8'h00;
    start_s = 1'b1;
    tick();
    data_s  = 8'hFF;
    n = 0;
    while (obs[3][1] && (n < 300)) begin
      n++;
      tick();
    end
    chk("stop2_frame_len", 32'(n), 32'd110);
    m = 0;
    while (!obs[3][1] && (m < 300)) begin
      m++;
      tick();
    end
    chk("stop2_idle_gap", 32'(m), 32'd1);
    start_s = 1'b0;
    repeat (14) tick();
    chk("stop2_second_data0", 32'(obs[3][3]), 32'd1);

    // Request while busy is ignored, no second frame
    wait_idle();
    data_s  = 8'hC3;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (40) tick();
    data_s  = 8'h3C;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    wait_idle();
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (obs[0][1]) n++;
    end
    chk("no_queued_frame", 32'(n), 32'd0);

    // Async reset mid-frame, then a clean frame
    data_s  = 8'h55;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (44) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx_inst%0d", i), 32'(obs[i][3]), 32'd1);
      chk($sformatf("rst_busy_inst%0d", i), 32'(obs[i][1]), 32'd0);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    run_vec(vecs[7]);

    // Random requests, checked cycle by cycle against the model
    for (int r = 0; r < 300; r++) begin
      data_s  = 8'($urandom);
      start_s = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 30)) tick();
    end
    start_s = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
